// File: rtl/ad9833_pkg.sv
// Shared AD9833 constants, serial-engine state encoding and frequency-word helper.
package ad9833_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned FREQ_W = 28;
  localparam int unsigned HALF_W = 14;

  localparam logic [WORD_W-1:0] B28_MASK   = 16'h2000;
  localparam logic [1:0]        FREQ0_ADDR = 2'b01;
  localparam logic [1:0]        FREQ1_ADDR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // Frequency register write: 2-bit register address on top of 14 tuning bits.
  function automatic logic [WORD_W-1:0] freq_word(input logic sel,
                                                  input logic [HALF_W-1:0] bits);
    return {(sel ? FREQ1_ADDR : FREQ0_ADDR), bits};
  endfunction

endpackage

// File: rtl/ad9833_word_tx.sv
// One-word serial engine: SETUP, 16-bit SHIFT, HOLD and GAP phases with a shared
// half-period divider. A start in the last GAP cycle chains straight into the next word.
module ad9833_word_tx
  import ad9833_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CLK_DIV = 4,
  parameter logic        CPOL    = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [N_CH-1:0]   sel_i,
  output logic              gap_end_c_o,
  output logic [N_CH-1:0]   fsync_o,
  output logic              sclk_o,
  output logic              sdata_o
);

  localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_e            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [3:0]        bit_q;
  logic [WORD_W-1:0] shreg_q;
  logic [N_CH-1:0]   fsync_q;
  logic              sclk_q;
  logic              sdata_q;

  logic div_end_c;
  logic load_c;

  assign div_end_c   = (div_q == DIV_LAST);
  assign gap_end_c_o = (state_q == ST_GAP) && div_end_c;
  assign load_c      = start_i && ((state_q == ST_IDLE) || gap_end_c_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      fsync_q <= '1;
      sclk_q  <= CPOL;
      sdata_q <= 1'b0;
    end else if (load_c) begin
      state_q <= ST_SETUP;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= word_i;
      fsync_q <= ~sel_i;
      sclk_q  <= CPOL;
      sdata_q <= word_i[WORD_W-1];
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SETUP: begin
          div_q <= div_q + DIV_W'(1);
          if (div_end_c) begin
            div_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          div_q <= div_q + DIV_W'(1);
          if (div_end_c) begin
            div_q <= '0;
            // sclk leaving idle is the chip's sample edge; data moves only when it returns
            if (sclk_q == CPOL) begin
              sclk_q <= ~CPOL;
            end else begin
              sclk_q <= CPOL;
              if (bit_q == 4'd15) begin
                state_q <= ST_HOLD;
              end else begin
                bit_q   <= bit_q + 4'd1;
                shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                sdata_q <= shreg_q[WORD_W-2];
              end
            end
          end
        end
        ST_HOLD: begin
          div_q <= div_q + DIV_W'(1);
          if (div_end_c) begin
            div_q   <= '0;
            state_q <= ST_GAP;
            fsync_q <= '1;
            sdata_q <= 1'b0;
          end
        end
        ST_GAP: begin
          div_q <= div_q + DIV_W'(1);
          if (div_end_c) begin
            div_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fsync_o = fsync_q;
  assign sclk_o  = sclk_q;
  assign sdata_o = sdata_q;

endmodule

// File: rtl/ad9833_multi_if.sv
// Multi-chip AD9833 loader: accepts a go request, builds the 1- or 3-word sequence
// for the selected chip and feeds it word by word to the serial engine.
module ad9833_multi_if
  import ad9833_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CLK_DIV = 4,
  parameter logic        CPOL    = 1'b1,
  parameter int unsigned SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [SEL_W-1:0]  ch_sel_i,
  input  logic              mode_i,
  input  logic              freq_sel_i,
  input  logic [WORD_W-1:0] control_i,
  input  logic [FREQ_W-1:0] freq_i,
  output logic              good_to_reset_go_o,
  output logic              send_complete_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [N_CH-1:0]   fsync_o,
  output logic              sclk_o,
  output logic              sdata_o
);

  logic              busy_q;
  logic              good_q;
  logic              done_q;
  logic              err_q;
  logic              start_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_idx_q;
  logic [N_CH-1:0]   sel_q;
  logic [WORD_W-1:0] words_q [3];

  logic              ch_ok_c;
  logic              more_c;
  logic              tx_gap_end_c;
  logic              tx_start_c;
  logic [1:0]        word_idx_c;
  logic [WORD_W-1:0] tx_word_c;

  assign ch_ok_c    = (32'(ch_sel_i) < N_CH);
  assign more_c     = (idx_q != last_idx_q);
  assign tx_start_c = start_q || (busy_q && tx_gap_end_c && more_c);

  // At the end of a GAP the engine reloads, so present the following word early.
  always_comb begin
    word_idx_c = tx_gap_end_c ? idx_q + 2'd1 : idx_q;
    tx_word_c  = words_q[0];
    case (word_idx_c)
      2'd1:    tx_word_c = words_q[1];
      2'd2:    tx_word_c = words_q[2];
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      good_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
      sel_q      <= '0;
      words_q    <= '{default: '0};
    end else begin
      good_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      if (done_q) begin
        busy_q <= 1'b0;
      end
      // busy stays high through the send_complete cycle, so go is only sampled once idle
      if (go_i && !busy_q) begin
        if (ch_ok_c) begin
          busy_q     <= 1'b1;
          good_q     <= 1'b1;
          start_q    <= 1'b1;
          idx_q      <= '0;
          last_idx_q <= mode_i ? 2'd2 : 2'd0;
          sel_q      <= N_CH'(1) << ch_sel_i;
          words_q[0] <= mode_i ? (control_i | B28_MASK) : control_i;
          words_q[1] <= freq_word(freq_sel_i, freq_i[HALF_W-1:0]);
          words_q[2] <= freq_word(freq_sel_i, freq_i[FREQ_W-1:HALF_W]);
        end else begin
          err_q <= 1'b1;
        end
      end
      if (busy_q && tx_gap_end_c) begin
        if (more_c) begin
          idx_q <= idx_q + 2'd1;
        end else begin
          done_q <= 1'b1;
        end
      end
    end
  end

  ad9833_word_tx #(
    .N_CH   (N_CH),
    .CLK_DIV(CLK_DIV),
    .CPOL   (CPOL)
  ) u_word_tx (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (tx_start_c),
    .word_i     (tx_word_c),
    .sel_i      (sel_q),
    .gap_end_c_o(tx_gap_end_c),
    .fsync_o    (fsync_o),
    .sclk_o     (sclk_o),
    .sdata_o    (sdata_o)
  );

  assign good_to_reset_go_o = good_q;
  assign send_complete_o    = done_q;
  assign busy_o             = busy_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_ad9833_multi_if.sv
// Scoreboard bench: two loaders (CPOL=1 and CPOL=0) share stimulus; per-instance
// monitors decode SPI frames and compare them with expected frames queued at request time.
module tb_ad9833_multi_if;

  typedef struct packed {
    logic [15:0] word;
    logic [1:0]  fs;
    logic        first;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst, go, mode, freq_sel;
  logic [1:0]  ch_sel;
  logic [15:0] control;
  logic [27:0] freq;
  logic [1:0]  good, done, busy, err, sclk, sdata;
  logic [1:0]  fsync [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int part_n [2] = '{0, 0};
  int tog_n  [2] = '{0, 0};
  int stab_n [2] = '{0, 0};
  frame_t exp_q0 [$];
  frame_t exp_q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit pop_exp(input int g, output frame_t f);
    f = '0;
    if (g == 0) begin
      if (exp_q0.size() == 0) return 1'b0;
      f = exp_q0.pop_front();
    end else begin
      if (exp_q1.size() == 0) return 1'b0;
      f = exp_q1.pop_front();
    end
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam logic CP = (g == 0) ? 1'b1 : 1'b0;

    ad9833_multi_if #(.N_CH(2), .CLK_DIV(4), .CPOL(CP), .SEL_W(2)) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .go_i              (go),
      .ch_sel_i          (ch_sel),
      .mode_i            (mode),
      .freq_sel_i        (freq_sel),
      .control_i         (control),
      .freq_i            (freq),
      .good_to_reset_go_o(good[g]),
      .send_complete_o   (done[g]),
      .busy_o            (busy[g]),
      .err_o             (err[g]),
      .fsync_o           (fsync[g]),
      .sclk_o            (sclk[g]),
      .sdata_o           (sdata[g])
    );

    // Frame decoder: captures sdata on each sclk edge leaving idle while a chip is selected.
    initial begin : mon
      logic [1:0]  pf, fv;
      logic        ps, pd;
      logic [15:0] sh;
      int          nb, t_lo, t_hi, gap;
      frame_t      e;
      bit          got;
      pf = 2'b11; fv = 2'b11; ps = CP; pd = 1'b0; sh = '0;
      nb = 0; t_lo = 0; t_hi = -100; gap = 0;
      forever begin
        @(posedge clk); #1;
        if (pf == 2'b11 && fsync[g] != 2'b11) begin
          t_lo = cyc; gap = cyc - t_hi; nb = 0; sh = '0; fv = fsync[g];
          chk("idle_lvl", 32'(sclk[g]), 32'(CP));
        end else if (pf != 2'b11 && fsync[g] != 2'b11) begin
          if (ps == CP && sclk[g] != CP) begin
            sh = {sh[14:0], sdata[g]};
            nb++;
            if (sdata[g] != pd) stab_n[g]++;
          end
        end else if (pf != 2'b11) begin
          t_hi = cyc;
          if (nb == 16) begin
            got = pop_exp(g, e);
            chk("sb_pop", 32'(got), 32'd1);
            if (got) begin
              chk("frame_word", 32'(sh), 32'(e.word));
              chk("frame_cs", 32'(fv), 32'(e.fs));
              chk("frame_len", cyc - t_lo, 136);
              if (!e.first) chk("frame_gap", gap, 4);
            end
          end else begin
            part_n[g]++;
          end
        end else if (sclk[g] != ps) begin
          tog_n[g]++;
        end
        pf = fsync[g]; ps = sclk[g]; pd = sdata[g];
      end
    end
  end

  task automatic send(input logic [1:0] ch, input logic m, input logic fs,
                      input logic [15:0] ctl, input logic [27:0] fq,
                      input bit hold_go, input bit no_wait);
    logic [15:0] w [3];
    logic [1:0]  addr;
    int          nw, k, extra, busy_lo;
    bit          seen;
    frame_t      f;
    addr = fs ? 2'b10 : 2'b01;
    w[0] = m ? (ctl | 16'h2000) : ctl;
    w[1] = {addr, fq[13:0]};
    w[2] = {addr, fq[27:14]};
    nw = m ? 3 : 1;
    for (int i = 0; i < nw; i++) begin
      f.word  = w[i];
      f.fs    = ~(2'b01 << ch);
      f.first = (i == 0);
      exp_q0.push_back(f);
      exp_q1.push_back(f);
    end
    ch_sel = ch; mode = m; freq_sel = fs; control = ctl; freq = fq; go = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk); #1;
      seen = good[0];
    end
    chk("accept", 32'(seen), 32'd1);
    if (!seen) begin
      go = 1'b0;
      return;
    end
    chk("accept_both", {29'd0, good[1], busy}, 32'd7);
    if (!hold_go) go = 1'b0;
    if (no_wait) return;
    k = 0; seen = 1'b0; extra = 0; busy_lo = 0;
    while (!seen && k < 2000) begin
      @(posedge clk); #1;
      k++;
      seen = done[0];
      if (good[0]) extra++;
      if (busy != 2'b11) busy_lo++;
    end
    chk("done_cycle", k, 1 + nw * 140);
    chk("done_both", 32'(done[1]), 32'd1);
    chk("no_reaccept", extra, 0);
    chk("busy_held", busy_lo, 0);
    go = 1'b0;
    @(posedge clk); #1;
    chk("busy_drop", {26'd0, busy, done, good}, 32'd0);
  endtask

  initial begin
    int n_evt;
    rst = 1'b1; go = 1'b0; ch_sel = '0; mode = 1'b0; freq_sel = 1'b0;
    control = '0; freq = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fsync", {28'd0, fsync[0], fsync[1]}, 32'hF);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_misc", {22'd0, sdata, busy, good, done, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(2'd0, 1'b0, 1'b0, 16'h2100, 28'h0000000, 1'b0, 1'b0);
    send(2'd0, 1'b1, 1'b0, 16'h0000, 28'h000000F, 1'b0, 1'b0);
    send(2'd1, 1'b1, 1'b1, 16'h0000, 28'hFFFFFFF, 1'b0, 1'b0);
    send(2'd1, 1'b0, 1'b0, 16'h0A5C, 28'h0000000, 1'b1, 1'b0);

    for (int c = 2; c < 4; c++) begin
      ch_sel = 2'(c); go = 1'b1;
      @(posedge clk); #1;
      chk("err_pulse", 32'(err), 32'd3);
      chk("err_quiet", {24'd0, good, busy, fsync[0], fsync[1]}, 32'h0F);
      go = 1'b0;
      @(posedge clk); #1;
      chk("err_clear", 32'(err), 32'd0);
    end

    send(2'd0, 1'b1, 1'b0, 16'h0100, 28'h1234567, 1'b0, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_fsync", {28'd0, fsync[0], fsync[1]}, 32'hF);
    chk("mid_rst_sclk_busy", {28'd0, sclk, busy}, 32'b0100);
    rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    n_evt = 0;
    repeat (450) begin
      @(posedge clk); #1;
      if (done != 2'b00 || good != 2'b00) n_evt++;
    end
    chk("no_done_after_rst", n_evt, 0);

    send(2'd1, 1'b0, 1'b1, 16'h5A3C, 28'h0000000, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;

    for (int g = 0; g < 2; g++) begin
      chk("sb_left", (g == 0) ? exp_q0.size() : exp_q1.size(), 0);
      chk("partial_frames", part_n[g], 1);
      chk("idle_toggles", tog_n[g], 0);
      chk("data_stable", stab_n[g], 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
